// File: rtl/neuron_decay_scheduler.sv
// Sweeps the neuron potential memory once per time step, pushing each nonzero
// potential through the decay engine (load, wait, time_step) and writing the result back.
module neuron_decay_scheduler #(
    parameter int NUM_NEURONS = 32,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode_cfg,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [31:0]       mem_wr_data,
    output logic              dec_load,
    output logic              dec_time_step,
    output logic [2:0]        dec_mode,
    output logic [31:0]       dec_new_potential,
    input  logic [31:0]       dec_potential_in
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        WAIT,
        TSTEP,
        CAPTURE,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       wr_data;
    logic [2:0]        mode;
    logic              skip;
    logic              last;

    assign skip = (mem_rd_data == 32'd0);
    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            wr_data  <= '0;
            mode     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx  <= '0;
                        mode <= mode_cfg;
                    end
                end
                LOAD: begin
                    wait_cnt <= WAIT_INIT;
                    if (skip && !last) idx <= idx + 1'b1;
                end
                WAIT:    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                // engine output is sampled on the edge that closes the strobe cycle
                TSTEP:   wr_data <= dec_potential_in;
                CAPTURE: if (!last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt         = state;
        busy              = (state != IDLE);
        done              = 1'b0;
        mem_rd_en         = 1'b0;
        mem_wr_en         = 1'b0;
        dec_load          = 1'b0;
        dec_time_step     = 1'b0;
        dec_new_potential = 32'd0;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: begin
                mem_rd_en = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                if (skip) begin
                    state_nxt = last ? DONE : READ;
                end else begin
                    dec_load          = 1'b1;
                    dec_new_potential = mem_rd_data;
                    state_nxt         = WAIT;
                end
            end
            WAIT: if (wait_cnt == '0) state_nxt = TSTEP;
            TSTEP: begin
                dec_time_step = 1'b1;
                state_nxt     = CAPTURE;
            end
            CAPTURE: begin
                mem_wr_en = 1'b1;
                state_nxt = last ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // index only moves between strobes, so it is also the held address
    assign mem_addr    = idx;
    assign mem_wr_data = wr_data;
    assign dec_mode    = mode;

endmodule

// File: tb/tb_neuron_decay_scheduler.sv
// Bench for neuron_decay_scheduler: memory and decay-engine models, a monitor
// that logs the bus activity of each sweep, and a schedule model built from per-neuron costs.
module tb_neuron_decay_scheduler;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int W  = 4;

    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic [2:0]    mode_cfg = 0;
    logic          busy, done, mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data = 0;
    logic [31:0]   mem_wr_data;
    logic          dec_load, dec_time_step;
    logic [2:0]    dec_mode;
    logic [31:0]   dec_new_potential;
    logic [31:0]   dec_potential_in;

    neuron_decay_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_cfg(mode_cfg),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
        .dec_load(dec_load), .dec_time_step(dec_time_step), .dec_mode(dec_mode),
        .dec_new_potential(dec_new_potential), .dec_potential_in(dec_potential_in)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // mode 1: v/2, mode 2: v/4, mode 3: v*3/4 (arithmetic shifts)
    function automatic logic [31:0] decay(input logic [2:0] m, input logic [31:0] v);
        case (m)
            3'd1:    return $signed(v) >>> 1;
            3'd2:    return $signed(v) >>> 2;
            3'd3:    return v - ($signed(v) >>> 2);
            default: return v;
        endcase
    endfunction

    // memory, preload port and decay engine models
    logic [31:0] mem [N];
    logic [31:0] pre [N];
    bit          pre_go = 0;
    logic [31:0] eng = 0;
    assign dec_potential_in = eng;

    always @(posedge clk) begin
        if (pre_go) mem <= pre;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (dec_load) eng <= decay(dec_mode, dec_new_potential);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    int          base;
    bit          active = 0, done_seen = 0;
    logic [2:0]  mode_exp;
    int          rd_a[$], rd_c[$], ld_c[$], ts_c[$], wr_a[$], wr_c[$];
    logic [31:0] ld_d[$], wr_d[$];
    int          busy_n, busy_first, busy_last, done_cyc;
    logic        prev_ld = 0, prev_ts = 0;

    always @(negedge clk) begin
        int r;
        if (!rst) begin
            chk("load_adjacent", {31'd0, dec_load & prev_ld}, 32'd0);
            chk("tstep_adjacent", {31'd0, dec_time_step & prev_ts}, 32'd0);
            chk("rd_wr_overlap", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
        end
        prev_ld = dec_load;
        prev_ts = dec_time_step;
        if (active) begin
            r = cyc - base + 1;
            chk("mode_hold", {29'd0, dec_mode}, {29'd0, mode_exp});
            if (mem_rd_en) begin rd_a.push_back(mem_addr); rd_c.push_back(r); end
            if (dec_load) begin ld_c.push_back(r); ld_d.push_back(dec_new_potential); end
            if (dec_time_step) ts_c.push_back(r);
            if (mem_wr_en) begin
                wr_a.push_back(mem_addr); wr_c.push_back(r); wr_d.push_back(mem_wr_data);
            end
            if (busy) begin
                busy_n++;
                if (busy_first == 0) busy_first = r;
                busy_last = r;
            end
            if (done) begin
                done_cyc  = r;
                done_seen = 1;
                active    = 0;
            end
        end
    end

    logic [31:0] exp_mem [N];

    task automatic preload(input logic [31:0] v0, v1, v2, v3);
        pre[0] = v0; pre[1] = v1; pre[2] = v2; pre[3] = v3;
        pre_go = 1;
        @(posedge clk); #1;
        pre_go = 0;
    endtask

    task automatic begin_sweep(input logic [2:0] m, input bit hold);
        for (int i = 0; i < N; i++) exp_mem[i] = mem[i];
        rd_a.delete(); rd_c.delete(); ld_c.delete(); ld_d.delete(); ts_c.delete();
        wr_a.delete(); wr_c.delete(); wr_d.delete();
        busy_n = 0; busy_first = 0; busy_last = 0; done_cyc = -1; done_seen = 0;
        mode_exp = m;
        mode_cfg = m;
        start    = 1;
        @(posedge clk); #1;
        base   = cyc;
        active = 1;
        if (!hold) start = 0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (done_seen) break;
        end
        #1;
        chk("sweep_timeout", {31'd0, done_seen}, 32'd1);
        active = 0;
    endtask

    // expected schedule: READ at t, skip costs 2, processed costs W+4
    task automatic check_sweep(input string tag);
        int t = 1;
        int er_a[$], er_c[$], el_c[$], et_c[$], ew_a[$], ew_c[$];
        logic [31:0] el_d[$], ew_d[$];
        for (int i = 0; i < N; i++) begin
            er_a.push_back(i); er_c.push_back(t);
            if (exp_mem[i] == 0) begin
                t += 2;
            end else begin
                el_c.push_back(t + 1); el_d.push_back(exp_mem[i]);
                et_c.push_back(t + W + 2);
                ew_c.push_back(t + W + 3); ew_a.push_back(i);
                ew_d.push_back(decay(mode_exp, exp_mem[i]));
                exp_mem[i] = decay(mode_exp, exp_mem[i]);
                t += W + 4;
            end
        end
        chk({tag, "_n_rd"}, rd_a.size(), er_a.size());
        for (int k = 0; k < er_a.size() && k < rd_a.size(); k++) begin
            chk({tag, "_rd_addr"}, rd_a[k], er_a[k]);
            chk({tag, "_rd_cyc"}, rd_c[k], er_c[k]);
        end
        chk({tag, "_n_ld"}, ld_c.size(), el_c.size());
        for (int k = 0; k < el_c.size() && k < ld_c.size(); k++) begin
            chk({tag, "_ld_cyc"}, ld_c[k], el_c[k]);
            chk({tag, "_ld_data"}, ld_d[k], el_d[k]);
        end
        chk({tag, "_n_ts"}, ts_c.size(), et_c.size());
        for (int k = 0; k < et_c.size() && k < ts_c.size(); k++)
            chk({tag, "_ts_cyc"}, ts_c[k], et_c[k]);
        chk({tag, "_n_wr"}, wr_a.size(), ew_a.size());
        for (int k = 0; k < ew_a.size() && k < wr_a.size(); k++) begin
            chk({tag, "_wr_addr"}, wr_a[k], ew_a[k]);
            chk({tag, "_wr_cyc"}, wr_c[k], ew_c[k]);
            chk({tag, "_wr_data"}, wr_d[k], ew_d[k]);
        end
        chk({tag, "_done_cyc"}, done_cyc, t);
        chk({tag, "_busy_n"}, busy_n, t);
        chk({tag, "_busy_first"}, busy_first, 1);
        chk({tag, "_busy_last"}, busy_last, t);
        for (int i = 0; i < N; i++) chk({tag, "_mem"}, mem[i], exp_mem[i]);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 0);
        chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 0);
        chk({tag, "_load"}, {31'd0, dec_load}, 0);
        chk({tag, "_tstep"}, {31'd0, dec_time_step}, 0);
        chk({tag, "_addr"}, {30'd0, mem_addr}, 0);
        chk({tag, "_wr_data"}, mem_wr_data, 0);
        chk({tag, "_new_pot"}, dec_new_potential, 0);
        chk({tag, "_mode"}, {29'd0, dec_mode}, 0);
    endtask

    initial begin
        logic [2:0]  nm;
        logic [31:0] rv [N];

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 0;

        // reset in the middle of a sweep
        preload(5, 5, 5, 5);
        begin_sweep(3'd2, 0);
        repeat (10) @(posedge clk);
        #1;
        active = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst_mid");
        rst = 0;
        @(posedge clk); #1;
        chk("rst_after_wr", {31'd0, mem_wr_en}, 0);
        chk("rst_after_busy", {31'd0, busy}, 0);

        // directed LIF2 sweep; restart after reset must read address 0 first
        preload(100, 64, 7, 1);
        begin_sweep(3'd1, 0);
        wait_done();
        chk("lif2_done_33", done_cyc, 33);
        check_sweep("lif2");

        // zero skip
        preload(8, 0, 0, 6);
        begin_sweep(3'd2, 0);
        wait_done();
        chk("skip_done_21", done_cyc, 21);
        check_sweep("skip");

        // single processed neuron, trailing skips end the sweep
        preload(8, 0, 0, 0);
        begin_sweep(3'd3, 0);
        wait_done();
        chk("lif24_wr", mem[0], 6);
        if (ld_c.size() > 0 && ts_c.size() > 0)
            chk("lif24_ts_gap", ts_c[0] - ld_c[0], W + 1);
        check_sweep("lif24");

        // randomized sweeps
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++)
                rv[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            preload(rv[0], rv[1], rv[2], rv[3]);
            begin_sweep(3'($urandom_range(1, 3)), 0);
            wait_done();
            check_sweep("rand");
        end

        // start held high with mode_cfg churning
        preload($urandom | 1, 0, $urandom | 1, 40);
        begin_sweep(3'd1, 1);
        nm = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #3;
            mode_cfg = 3'($urandom_range(0, 7));
            nm = mode_cfg;
            if (done_seen) break;
        end
        chk("hold_timeout", {31'd0, done_seen}, 1);
        active = 0;
        chk("hold_idle_busy", {31'd0, busy}, 0);
        chk("hold_idle_rd", {31'd0, mem_rd_en}, 0);
        check_sweep("hold");
        @(posedge clk); #1;
        chk("hold_restart_busy", {31'd0, busy}, 1);
        chk("hold_restart_rd", {31'd0, mem_rd_en}, 1);
        chk("hold_restart_addr", {30'd0, mem_addr}, 0);
        chk("hold_restart_mode", {29'd0, dec_mode}, {29'd0, nm});
        start = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        chk("hold_sweep2_done", {31'd0, done}, 1);
        @(posedge clk); #1;
        chk("final_idle", {31'd0, busy}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
